// File: rtl/chip_chk_pkg.sv
// Shared types and defaults for the socket vector tester.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package chip_chk_pkg;

    // Widest socket supported; narrower sockets zero-extend into the vector word.
    localparam int MAX_PINS          = 16;
    localparam int DEF_NUM_PINS      = 14;
    localparam int DEF_DEPTH         = 16;
    localparam int DEF_SETTLE_CYCLES = 4;
    localparam int DEF_ERR_W         = 8;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    typedef struct packed {
        logic [MAX_PINS-1:0] drive;
        logic [MAX_PINS-1:0] oe;
        logic [MAX_PINS-1:0] expected;
        logic [MAX_PINS-1:0] mask;
        logic                last;
    } vec_t;

    // A pin counts as a mismatch only when it is compared (mask=1) and sampled (oe=0).
    function automatic logic vec_mismatch(input vec_t v, input logic [MAX_PINS-1:0] pins);
        return |((pins ^ v.expected) & v.mask & ~v.oe);
    endfunction

endpackage

// File: rtl/chk_settle_timer.sv
// Loadable down-counter that stops at zero and flags it.
// Latency: zero flag follows the count register; load wins over counting.
// Backpressure: none; the owner decides when to load and when to look at zero.
module chk_settle_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Load on request, otherwise count down and hold at zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/chip_vector_tester.sv
// Socket vector tester: fetches vectors, drives the pads, samples after settling, counts mismatches.
// Latency: 2 + SETTLE_CYCLES cycles per vector; done rises on the edge that samples the final vector.
// Backpressure: none; starts arriving while busy are ignored. Optional build macro CHIP_CHK_STOP_ON_FAIL_EN.
module chip_vector_tester
    import chip_chk_pkg::*;
#(
    parameter  int NUM_PINS      = DEF_NUM_PINS,
    parameter  int DEPTH         = DEF_DEPTH,
    parameter  int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter  int ERR_W         = DEF_ERR_W,
    localparam int AW            = $clog2(DEPTH)
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Run,
    output logic [AW-1:0]       vec_addr,
    input  logic [NUM_PINS-1:0] vec_drive,
    input  logic [NUM_PINS-1:0] vec_oe,
    input  logic [NUM_PINS-1:0] vec_expect,
    input  logic [NUM_PINS-1:0] vec_mask,
    input  logic                vec_last,
    output logic [NUM_PINS-1:0] pin_out,
    output logic [NUM_PINS-1:0] pin_oe,
    input  logic [NUM_PINS-1:0] pin_in,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ERR_W-1:0]    err_count,
    output logic [AW-1:0]       fail_addr
);

    // Two synchroniser flops plus the sample edge must fit inside the settle window.
    if (SETTLE_CYCLES < 3) begin : g_bad_settle
        $error("chip_vector_tester: SETTLE_CYCLES must be at least 3");
    end
    if (NUM_PINS < 1 || NUM_PINS > MAX_PINS) begin : g_bad_pins
        $error("chip_vector_tester: NUM_PINS out of range");
    end

    localparam int              TW        = $clog2(SETTLE_CYCLES + 1);
    localparam logic [TW-1:0]   SETTLE_LD = TW'(SETTLE_CYCLES - 1);
    localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    state_t              state;
    logic                run_q;
    logic                start;
    logic [NUM_PINS-1:0] pin_meta;
    logic [NUM_PINS-1:0] pin_sync;
    vec_t                vec_q;
    logic                word_pend;
    logic                settled;
    logic                mism;
    logic                end_of_list;
    logic                stop_now;

    assign start = run_q & ~Run;

    // Remember last Run level so only a falling edge starts a test.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            run_q <= 1'b1;
        end else begin
            run_q <= Run;
        end
    end

    // Bring the asynchronous pad inputs into the clock domain.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            pin_meta <= '0;
            pin_sync <= '0;
        end else begin
            pin_meta <= pin_in;
            pin_sync <= pin_meta;
        end
    end

    // Pads are driven straight from the latched vector word, so they are registered outputs
    // and hold their value through FETCH of the next vector.
    assign pin_out = vec_q.drive[NUM_PINS-1:0];
    assign pin_oe  = vec_q.oe[NUM_PINS-1:0];

    assign mism        = vec_mismatch(vec_q, MAX_PINS'(pin_sync));
    assign end_of_list = vec_q.last || (vec_addr == LAST_ADDR);
`ifdef CHIP_CHK_STOP_ON_FAIL_EN
    assign stop_now    = end_of_list || mism;
`else
    assign stop_now    = end_of_list;
`endif

    // Settle window starts counting on the FETCH edge; the word lands one edge later.
    chk_settle_timer #(
        .W (TW)
    ) u_settle (
        .clk      (Clk),
        .reset_n  (Reset),
        .load     (state == FETCH),
        .load_val (SETTLE_LD),
        .zero     (settled)
    );

    // Test sequencer with registered status outputs.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state     <= IDLE;
            vec_addr  <= '0;
            vec_q     <= '0;
            word_pend <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= FETCH;
                        vec_addr  <= '0;
                        vec_q     <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        err_count <= '0;
                        fail_addr <= '0;
                    end
                end
                FETCH: begin
                    state     <= DRIVE;
                    word_pend <= 1'b1;
                end
                DRIVE: begin
                    // Registered ROM output is valid on the first DRIVE edge; capture it once.
                    if (word_pend) begin
                        word_pend <= 1'b0;
                        vec_q     <= '{drive:    MAX_PINS'(vec_drive),
                                       oe:       MAX_PINS'(vec_oe),
                                       expected: MAX_PINS'(vec_expect),
                                       mask:     MAX_PINS'(vec_mask),
                                       last:     vec_last};
                    end
                    if (settled) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (mism) begin
                        if (err_count != ERR_MAX) begin
                            err_count <= err_count + 1'b1;
                        end
                        if (err_count == '0) begin
                            fail_addr <= vec_addr;
                        end
                    end
                    if (stop_now) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0) && !mism;
                    end else begin
                        state    <= FETCH;
                        vec_addr <= vec_addr + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chip_vector_tester.sv
// Directed bench: 7400 quad-NAND socket model behind the tester, plus a second
// narrow-counter tester whose vectors all fail to exercise counter saturation.
module tb_chip_vector_tester;
    import chip_chk_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Run;

    // Main tester (defaults) and its socket
    logic [3:0]  vec_addr, fail_addr;
    logic [13:0] pin_out, pin_oe, pin_in;
    logic        busy, done, pass;
    logic [7:0]  err_count;
    vec_t        rom [16];
    vec_t        rom_q;

    // Saturation tester: ERR_W = 2, every vector fails, last at address 4
    logic [3:0]  vec_addr2, fail_addr2;
    logic [13:0] pin_out2, pin_oe2, pin_in2;
    logic        busy2, done2, pass2;
    logic [1:0]  err_count2;
    vec_t        rom2_q;
    vec_t        bad_word;

    int n_vec = 0;
    int n_bad = 0;
    int cyc;

    always #10 Clk = ~Clk;

    chip_vector_tester u_dut (
        .Clk(Clk), .Reset(Reset), .Run(Run),
        .vec_addr(vec_addr),
        .vec_drive(rom_q.drive[13:0]), .vec_oe(rom_q.oe[13:0]),
        .vec_expect(rom_q.expected[13:0]), .vec_mask(rom_q.mask[13:0]),
        .vec_last(rom_q.last),
        .pin_out(pin_out), .pin_oe(pin_oe), .pin_in(pin_in),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_addr(fail_addr)
    );

    chip_vector_tester #(.ERR_W(2)) u_dut2 (
        .Clk(Clk), .Reset(Reset), .Run(Run),
        .vec_addr(vec_addr2),
        .vec_drive(rom2_q.drive[13:0]), .vec_oe(rom2_q.oe[13:0]),
        .vec_expect(rom2_q.expected[13:0]), .vec_mask(rom2_q.mask[13:0]),
        .vec_last(rom2_q.last),
        .pin_out(pin_out2), .pin_oe(pin_oe2), .pin_in(pin_in2),
        .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err_count2), .fail_addr(fail_addr2)
    );

    // Registered vector ROMs
    always @(posedge Clk) rom_q  <= rom[vec_addr];
    always @(posedge Clk) rom2_q <= (vec_addr2 == 4'd4) ? '{drive: '0, oe: '0, expected: 16'h3FFF, mask: 16'h3FFF, last: 1'b1}
                                                        : bad_word;

    // 7400 model: gates (1,2)->3, (4,5)->6, (9,10)->8, (12,13)->11, index = pin - 1
    logic [13:0] pad, dev;
    always_comb begin
        pad     = pin_out & pin_oe;
        dev     = '0;
        dev[2]  = ~(pad[0] & pad[1]);
        dev[5]  = ~(pad[3] & pad[4]);
        dev[7]  = ~(pad[8] & pad[9]);
        dev[10] = ~(pad[11] & pad[12]);
        pin_in  = pad | (dev & ~pin_oe);
    end
    assign pin_in2 = pin_out2 & pin_oe2;

    function automatic vec_t nand_vec(input logic a, input logic b, input logic last);
        vec_t v;
        v          = '0;
        v.drive[0] = a;  v.drive[1]  = b;
        v.drive[3] = a;  v.drive[4]  = b;
        v.drive[8] = a;  v.drive[9]  = b;
        v.drive[11] = a; v.drive[12] = b;
        v.drive[13] = 1'b1;
        v.oe       = 16'h3B5B;
        v.mask     = 16'h04A4;
        v.expected = (a & b) ? 16'h0000 : 16'h04A4;
        v.last     = last;
        return v;
    endfunction

    task automatic load_nand4();
        for (int i = 0; i < 16; i++) rom[i] = nand_vec(i[1], i[0], i == 3);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle Run pulse; cyc counts the Run-low cycle as cycle 1.
    task automatic start_and_wait(input string tag, input int budget);
        Run = 1'b0;
        cyc = 1;
        tick();
        cyc++;
        Run = 1'b1;
        chk({tag, "_busy_at_start"}, busy, 1);
        chk({tag, "_tristate_at_start"}, pin_oe, 0);
        while (!done && cyc < budget) begin
            tick();
            cyc++;
        end
        chk({tag, "_done"}, done, 1);
    endtask

    initial begin
        Reset    = 1'b0;
        Run      = 1'b1;
        bad_word = '{drive: '0, oe: '0, expected: 16'h3FFF, mask: 16'h3FFF, last: 1'b0};
        load_nand4();
        repeat (3) tick();

        // Reset state
        chk("rst_pin_oe", pin_oe, 0);
        chk("rst_pin_out", pin_out, 0);
        chk("rst_vec_addr", vec_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_count, 0);
        chk("rst_fail_addr", fail_addr, 0);
        Reset = 1'b1;
        repeat (2) tick();

        // All four NAND vectors match
        start_and_wait("t1", 200);
        chk("t1_cycles", cyc, 26);
        chk("t1_pass", pass, 1);
        chk("t1_err", err_count, 0);
        chk("t1_fail_addr", fail_addr, 0);
        chk("t1_busy", busy, 0);
        chk("t1_vec_addr", vec_addr, 3);
        repeat (3) tick();
        chk("t1_hold_oe", pin_oe, 14'h3B5B);
        chk("t1_hold_out", pin_out, 14'h3B1B);
        chk("t1_done_held", done, 1);

        // Wrong expectation at vector 2 (output pin 3)
        rom[2].expected ^= 16'h0004;
        start_and_wait("t2", 200);
        chk("t2_cycles", cyc, 26);
        chk("t2_pass", pass, 0);
        chk("t2_err", err_count, 1);
        chk("t2_fail_addr", fail_addr, 2);
        repeat (3) tick();

        // Failures at vectors 1 and 3
        load_nand4();
        rom[1].expected ^= 16'h0020;
        rom[3].expected ^= 16'h0400;
        start_and_wait("t3", 200);
`ifdef CHIP_CHK_STOP_ON_FAIL_EN
        chk("t3_cycles", cyc, 14);
        chk("t3_err", err_count, 1);
        chk("t3_vec_addr", vec_addr, 1);
`else
        chk("t3_cycles", cyc, 26);
        chk("t3_err", err_count, 2);
        chk("t3_vec_addr", vec_addr, 3);
`endif
        chk("t3_fail_addr", fail_addr, 1);
        chk("t3_pass", pass, 0);
        repeat (3) tick();

        // Reset while vector 2 is being driven (vector 1 already failed)
        load_nand4();
        rom[1].expected ^= 16'h0020;
        Run = 1'b0;
        tick();
        Run = 1'b1;
        cyc = 0;
        while (vec_addr != 4'd2 && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("t4_reached_addr2", vec_addr, 2);
        repeat (2) tick();
        chk("t4_driving_vec2", pin_oe, 14'h3B5B);
`ifndef CHIP_CHK_STOP_ON_FAIL_EN
        chk("t4_err_before_reset", err_count, 1);
`endif
        Reset = 1'b0;
        tick();
        chk("t4_rst_oe", pin_oe, 0);
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_err", err_count, 0);
        chk("t4_rst_addr", vec_addr, 0);
        Reset = 1'b1;
        rom[1] = nand_vec(1'b0, 1'b1, 1'b0);
        tick();
        start_and_wait("t4r", 200);
        chk("t4r_cycles", cyc, 26);
        chk("t4r_pass", pass, 1);
        repeat (3) tick();

        // No last flag: runs to DEPTH-1; Run held low, then pulsed while busy
        for (int i = 0; i < 16; i++) rom[i] = nand_vec(i[1], i[0], 1'b0);
        Run = 1'b0;
        cyc = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            cyc++;
        end
        Run = 1'b1;
        repeat (2) begin
            tick();
            cyc++;
        end
        Run = 1'b0;
        tick();
        cyc++;
        Run = 1'b1;
        while (!done && cyc < 300) begin
            tick();
            cyc++;
        end
        chk("t5_done", done, 1);
        chk("t5_cycles", cyc, 98);
        chk("t5_vec_addr", vec_addr, 15);
        chk("t5_pass", pass, 1);
        repeat (20) tick();
        chk("t5_no_restart", busy, 0);
        chk("t5_done_held", done, 1);

        // Saturation tester: five failing vectors on a 2-bit counter
        chk("sat_done", done2, 1);
        chk("sat_pass", pass2, 0);
        chk("sat_fail_addr", fail_addr2, 0);
`ifdef CHIP_CHK_STOP_ON_FAIL_EN
        chk("sat_err", err_count2, 1);
`else
        chk("sat_err", err_count2, 3);
`endif

        // Differences only on uncompared bits
        load_nand4();
        rom[1].expected ^= 16'h0041;
        rom[1].mask     |= 16'h0001;
        rom[2].expected ^= 16'h0020;
        rom[2].mask     &= ~16'h0020;
        start_and_wait("t6", 200);
        chk("t6_pass", pass, 1);
        chk("t6_err", err_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
